// File: rtl/fre_pkg.sv
// Shared constants for the frequency meter and the generator-side word path:
// gate-select encodings, Hz multipliers, DDS scaling and Hz saturation.
package fre_pkg;

  typedef enum logic [1:0] {
    GSEL_1S    = 2'd0,
    GSEL_100MS = 2'd1,
    GSEL_10MS  = 2'd2,
    GSEL_RSVD  = 2'd3
  } gate_sel_e;

  localparam logic [6:0] MULT_1S    = 7'd1;
  localparam logic [6:0] MULT_100MS = 7'd10;
  localparam logic [6:0] MULT_10MS  = 7'd100;

  // 2^32 / 125 MHz in Q16
  localparam int unsigned DDS_FW_PER_HZ_Q16 = 32'd2251800;

  localparam logic [23:0] HZ_SAT = 24'hFF_FFFF;

  function automatic logic [6:0] gate_mult(input gate_sel_e sel);
    case (sel)
      GSEL_100MS: gate_mult = MULT_100MS;
      GSEL_10MS:  gate_mult = MULT_10MS;
      default:    gate_mult = MULT_1S;
    endcase
  endfunction

  // Rounded Hz -> DDS word; 48-bit product keeps the full range of a 24-bit Hz value.
  function automatic logic [31:0] hz_to_word(input logic [23:0] hz,
                                             input logic [31:0] fw_q16);
    logic [47:0] prod;
    prod = 48'(hz) * 48'(fw_q16) + 48'h0000_0000_8000;
    hz_to_word = prod[47:16];
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse;
// pin-to-pulse latency is three clocks.
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_pulse
);

  logic meta;
  logic sync_d1;
  logic sync_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      sync_d1    <= 1'b0;
      sync_d2    <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      meta       <= async_in;
      sync_d1    <= meta;
      sync_d2    <= sync_d1;
      edge_pulse <= sync_d1 & ~sync_d2;
    end
  end

endmodule

// File: rtl/fre_meas.sv
// Gate-time frequency meter: counts input edges over a clock-timed gate,
// reports saturating Hz and the equivalent DDS frequency control word.
module fre_meas
  import fre_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned FW_PER_HZ_Q16 = DDS_FW_PER_HZ_Q16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  gate_sel,
  input  logic        sig_in,
  output logic [23:0] fre_oled_out,
  output logic [31:0] fre_word_out,
  output logic        ovf_out,
  output logic        meas_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_CALC,
    ST_OUT
  } state_e;

  localparam logic [31:0] LAST_1S    = 32'(CLK_FREQ - 1);
  localparam logic [31:0] LAST_100MS = 32'(CLK_FREQ / 10 - 1);
  localparam logic [31:0] LAST_10MS  = 32'(CLK_FREQ / 100 - 1);

  state_e      state;
  logic        edge_pulse;
  logic [31:0] gate_cnt;
  logic [31:0] gate_last;
  logic [31:0] edge_cnt;
  logic [6:0]  mult_r;

  logic [31:0] nxt_last;
  logic [6:0]  nxt_mult;
  logic [38:0] hz_full;
  logic        hz_ovf;
  logic [23:0] hz_sat;
  logic [31:0] word;

  sig_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (sig_in),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    nxt_mult = gate_mult(gate_sel_e'(gate_sel));
    case (gate_sel_e'(gate_sel))
      GSEL_100MS: nxt_last = LAST_100MS;
      GSEL_10MS:  nxt_last = LAST_10MS;
      default:    nxt_last = LAST_1S;
    endcase
  end

  always_comb begin
    hz_full = 39'(edge_cnt) * 39'(mult_r);
    hz_ovf  = |hz_full[38:24];
    hz_sat  = hz_ovf ? HZ_SAT : hz_full[23:0];
    word    = hz_to_word(hz_sat, 32'(FW_PER_HZ_Q16));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      gate_cnt     <= '0;
      gate_last    <= '0;
      edge_cnt     <= '0;
      mult_r       <= '0;
      fre_oled_out <= '0;
      fre_word_out <= '0;
      ovf_out      <= 1'b0;
      meas_valid   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        // OUT shares IDLE's start logic so back-to-back gates lose only CALC+OUT.
        ST_IDLE, ST_OUT: begin
          if (en) begin
            state     <= ST_GATE;
            busy      <= 1'b1;
            gate_last <= nxt_last;
            mult_r    <= nxt_mult;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GATE: begin
          if (!en) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            if (edge_pulse && (edge_cnt != '1)) begin
              edge_cnt <= edge_cnt + 32'd1;
            end
            if (gate_cnt == gate_last) begin
              state <= ST_CALC;
              busy  <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + 32'd1;
            end
          end
        end
        ST_CALC: begin
          fre_oled_out <= hz_sat;
          fre_word_out <= word;
          ovf_out      <= hz_ovf;
          meas_valid   <= 1'b1;
          state        <= ST_OUT;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fre_meas.sv
// Self-checking bench for fre_meas with a 1000 Hz clock so a 1 s gate is 1000 cycles.
module tb_fre_meas;

  localparam int unsigned CLK = 1000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  gate_sel;
  logic        sig_in;
  logic [23:0] fre_oled_out;
  logic [31:0] fre_word_out;
  logic        ovf_out;
  logic        meas_valid;
  logic        busy;

  int unsigned period;
  int unsigned prev_period;
  int          total;
  int          bad;
  logic [31:0] fcnt;

  fre_meas #(.CLK_FREQ(CLK), .FW_PER_HZ_Q16(2251800)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .gate_sel     (gate_sel),
    .sig_in       (sig_in),
    .fre_oled_out (fre_oled_out),
    .fre_word_out (fre_word_out),
    .ovf_out      (ovf_out),
    .meas_valid   (meas_valid),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Square-wave source; period 0 means static low.
  initial begin
    sig_in = 1'b0;
    forever begin
      if (period == 0) begin
        sig_in = 1'b0;
        @(negedge clk);
      end else begin
        sig_in = 1'b1;
        repeat (period / 2) @(negedge clk);
        sig_in = 1'b0;
        repeat (period - period / 2) @(negedge clk);
      end
    end
  end

  // Reference model: Hz = edges / gate seconds, clipped to 24 bits; word by rounding.
  function automatic longint unsigned gate_len(input logic [1:0] sel);
    case (sel)
      2'd1:    return CLK / 10;
      2'd2:    return CLK / 100;
      default: return CLK;
    endcase
  endfunction

  function automatic longint unsigned raw_hz(input longint unsigned edges, input logic [1:0] sel);
    return edges * CLK / gate_len(sel);
  endfunction

  function automatic longint unsigned sat_hz(input longint unsigned hz);
    return (hz > 64'd16777215) ? 64'd16777215 : hz;
  endfunction

  function automatic longint unsigned model_word(input longint unsigned hz);
    return ((hz * 64'd2251800 + 64'd32768) >> 16) & 64'hFFFF_FFFF;
  endfunction

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (meas_valid) ok = 1'b1;
    end
  endtask

  task automatic set_vector(input logic [1:0] sel, input int unsigned p);
    @(negedge clk);
    en       = 1'b0;
    gate_sel = sel;
    period   = p;
    repeat (prev_period + p + 20) @(negedge clk);
    prev_period = p;
  endtask

  task automatic measure(input string nm, input logic [1:0] sel, input int unsigned p,
                         input longint unsigned exp_hz);
    int cyc;
    bit ok;
    set_vector(sel, p);
    en = 1'b1;
    wait_valid(1200, cyc, ok);
    chk({nm, "_seen"}, ok, 1);
    chk({nm, "_hz"}, fre_oled_out, sat_hz(exp_hz));
    chk({nm, "_word"}, fre_word_out, model_word(sat_hz(exp_hz)));
    chk({nm, "_ovf"}, ovf_out, (exp_hz > 64'd16777215) ? 1 : 0);
    @(negedge clk);
    chk({nm, "_pulse1"}, meas_valid, 0);
  endtask

  typedef struct {
    logic [1:0]        sel;
    int unsigned       period;
    longint unsigned   exp_hz;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] cnt;
  } fvec_t;

  vec_t  vecs[10];
  fvec_t fvecs[5];

  initial begin
    int cyc;
    bit ok;
    int n;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    en = 1'b0;
    gate_sel = 2'd0;
    period = 0;
    prev_period = 0;

    vecs[0] = '{2'd0, 10, 100};
    vecs[1] = '{2'd1, 10, 100};
    vecs[2] = '{2'd2, 10, 100};
    vecs[3] = '{2'd3, 10, 100};
    vecs[4] = '{2'd0, 4, 250};
    vecs[5] = '{2'd1, 5, 200};
    vecs[6] = '{2'd2, 2, 500};
    vecs[7] = '{2'd0, 0, 0};
    vecs[8] = '{2'd1, 50, 20};
    vecs[9] = '{2'd0, 1000, 1};

    fvecs[0] = '{2'd0, 32'h0100_0000};
    fvecs[1] = '{2'd0, 32'h00FF_FFFF};
    fvecs[2] = '{2'd2, 32'd167773};
    fvecs[3] = '{2'd2, 32'd167772};
    fvecs[4] = '{2'd1, 32'hFFFF_FFFF};

    repeat (3) @(negedge clk);
    chk("rst_hz", fre_oled_out, 0);
    chk("rst_word", fre_word_out, 0);
    chk("rst_ovf", ovf_out, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      measure($sformatf("vec%0d", i), vecs[i].sel, vecs[i].period, vecs[i].exp_hz);
    end

    for (int i = 0; i < 5; i++) begin
      set_vector(fvecs[i].sel, 10);
      fcnt = fvecs[i].cnt;
      force dut.edge_cnt = fcnt;
      en = 1'b1;
      wait_valid(1200, cyc, ok);
      release dut.edge_cnt;
      chk($sformatf("force%0d_seen", i), ok, 1);
      chk($sformatf("force%0d_hz", i), fre_oled_out, sat_hz(raw_hz(fvecs[i].cnt, fvecs[i].sel)));
      chk($sformatf("force%0d_word", i), fre_word_out,
          model_word(sat_hz(raw_hz(fvecs[i].cnt, fvecs[i].sel))));
      chk($sformatf("force%0d_ovf", i), ovf_out,
          (raw_hz(fvecs[i].cnt, fvecs[i].sel) > 64'd16777215) ? 1 : 0);
    end

    for (int i = 0; i < 12; i++) begin
      logic [1:0]      sel;
      int unsigned     p;
      longint unsigned len;
      sel = 2'($urandom_range(0, 3));
      len = gate_len(sel);
      p = 2;
      for (int t = 0; t < 64; t++) begin
        int unsigned c;
        c = $urandom_range(2, 50);
        if ((len % c) == 0) begin
          p = c;
          break;
        end
      end
      measure($sformatf("rnd%0d", i), sel, p, raw_hz(len / p, sel));
    end

    // Back-to-back 100-cycle gates: pulses 102 cycles apart.
    set_vector(2'd1, 10);
    en = 1'b1;
    wait_valid(1200, cyc, ok);
    chk("b2b_first_seen", ok, 1);
    chk("b2b_first_latency", cyc, 102);
    wait_valid(300, cyc, ok);
    chk("b2b_interval", cyc, 102);
    chk("b2b_hz", fre_oled_out, 100);

    // Asynchronous reset mid-gate clears outputs without a clock edge.
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hz", fre_oled_out, 0);
    chk("arst_word", fre_word_out, 0);
    chk("arst_ovf", ovf_out, 0);
    chk("arst_valid", meas_valid, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(300, cyc, ok);
    chk("arst_restart_latency", cyc, 102);
    wait_valid(300, cyc, ok);
    chk("arst_second_hz", fre_oled_out, 100);

    // Static input: zero result still pulses, every 12 cycles.
    set_vector(2'd2, 0);
    en = 1'b1;
    wait_valid(200, cyc, ok);
    chk("static_seen", ok, 1);
    chk("static_hz", fre_oled_out, 0);
    chk("static_word", fre_word_out, 0);
    wait_valid(200, cyc, ok);
    chk("static_interval", cyc, 12);

    // Abort mid-gate: outputs hold, no pulse, then a fresh full gate.
    set_vector(2'd0, 10);
    en = 1'b1;
    wait_valid(1200, cyc, ok);
    chk("abort_pre_latency", cyc, 1002);
    chk("abort_pre_hz", fre_oled_out, 100);
    chk("abort_pre_word", fre_word_out, 3436);
    repeat (300) @(negedge clk);
    chk("abort_busy_gate", busy, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy_next", busy, 0);
    n = 0;
    repeat (1200) begin
      @(negedge clk);
      if (meas_valid) n++;
    end
    chk("abort_no_valid", n, 0);
    chk("abort_hold_hz", fre_oled_out, 100);
    chk("abort_hold_word", fre_word_out, 3436);
    chk("abort_hold_ovf", ovf_out, 0);
    en = 1'b1;
    wait_valid(1200, cyc, ok);
    chk("abort_restart_latency", cyc, 1002);
    chk("abort_restart_hz", fre_oled_out, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
